// File: rtl/crucial_token_select_if.sv
// crucial_token_select_if: sorted-index input, map-memory read port and crucial-token output of crucial_token_select
//   in_valid/in_index/in_ready/budget/read_finish : sorted index stream from the sorter
//   map_addr/map_ren/map_rdata                    : binary-map memory read port
//   tok_out/tok_valid/tok_ready                   : crucial-token stream to the gather stage
//   crucial_cnt/find_finish                       : per-frame count and end-of-frame pulse
interface crucial_token_select_if #(
    parameter int IDX_W  = 10,
    parameter int MAP_W  = 16,
    parameter int ADDR_W = 17
);
    logic              in_valid;
    logic [IDX_W-1:0]  in_index;
    logic              in_ready;
    logic [IDX_W:0]    budget;
    logic              read_finish;
    logic [ADDR_W-1:0] map_addr;
    logic              map_ren;
    logic [MAP_W-1:0]  map_rdata;
    logic [IDX_W-1:0]  tok_out;
    logic              tok_valid;
    logic              tok_ready;
    logic [IDX_W:0]    crucial_cnt;
    logic              find_finish;
    modport slave (
        input  in_valid, in_index, budget, map_rdata, tok_ready,
        output in_ready, read_finish, map_addr, map_ren, tok_out, tok_valid, crucial_cnt, find_finish
    );
    modport master (
        output in_valid, in_index, budget, map_rdata, tok_ready,
        input  in_ready, read_finish, map_addr, map_ren, tok_out, tok_valid, crucial_cnt, find_finish
    );
endinterface

// File: rtl/crucial_token_select.sv
// crucial_token_select: walks DIMEN score-sorted token indices, emits each unsuppressed one and suppresses its map row
//   CLK, RESET : clock and synchronous active-high reset
//   EN         : global enable; low freezes all state and outputs, including in-flight map reads
//   bus        : crucial_token_select_if.slave carrying index input, map-memory port and token output
module crucial_token_select #(
    parameter int DIMEN   = 1024,
    parameter int IDX_W   = 10,
    parameter int MAP_W   = 16,
    parameter int ADDR_W  = 17,
    parameter int MEM_LAT = 1
) (
    input logic CLK,
    input logic RESET,
    input logic EN,
    crucial_token_select_if.slave bus
);
    localparam int NW = DIMEN / MAP_W;
    localparam int WI_W = $clog2(NW + 1);
    localparam logic [IDX_W:0] DIM = DIMEN;
    typedef enum logic [2:0] {IDLE, LOAD, SCAN, EMIT, FETCH, DONE} state_t;
    state_t st, nxt;
    logic [IDX_W-1:0] order [DIMEN];
    logic [DIMEN-1:0] sup, mask;
    logic [IDX_W-1:0] n, tok, cur;
    logic [IDX_W:0] p, bud, cnt;
    logic [WI_W-1:0] wi;
    logic [MEM_LAT-1:0] pv;
    logic [WI_W-1:0] pw [MEM_LAT];
    logic acc, stop, last, rf;
    always_comb begin
        bus.in_ready = st == IDLE || st == LOAD;
        bus.tok_valid = st == EMIT;
        bus.tok_out = tok;
        bus.map_ren = st == FETCH && wi < WI_W'(NW);
        bus.map_addr = ADDR_W'(tok) + ADDR_W'(wi) * ADDR_W'(DIMEN);
        bus.find_finish = st == DONE;
        bus.read_finish = rf;
        bus.crucial_cnt = cnt;
        acc = EN && bus.in_valid && bus.in_ready;
        cur = order[p[IDX_W-1:0]];
        stop = p == DIM || (bud != '0 && cnt == bud);
        // words come back in issue order, so the tail of the pipe tagged with the last word ends the fetch
        last = pv[MEM_LAT-1] && pw[MEM_LAT-1] == WI_W'(NW - 1);
        mask = pv[MEM_LAT-1] ? DIMEN'(bus.map_rdata) << (int'(pw[MEM_LAT-1]) * MAP_W) : '0;
        nxt = st;
        case (st)
            IDLE:    nxt = acc ? LOAD : IDLE;
            LOAD:    nxt = acc && n == IDX_W'(DIMEN - 1) ? SCAN : LOAD;
            SCAN:    nxt = stop ? DONE : sup[cur] ? SCAN : EMIT;
            EMIT:    nxt = bus.tok_ready ? FETCH : EMIT;
            FETCH:   nxt = last ? SCAN : FETCH;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET)
            st <= IDLE;
        else if (EN)
            st <= nxt;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            order <= '{default: '0};
            sup <= '0;
            n <= '0;
            tok <= '0;
            p <= '0;
            bud <= '0;
            cnt <= '0;
            wi <= '0;
            pv <= '0;
            pw <= '{default: '0};
            rf <= 1'b0;
        end else if (EN) begin
            rf <= 1'b0;
            pv[0] <= bus.map_ren;
            pw[0] <= wi;
            for (int i = 1; i < MEM_LAT; i++) begin
                pv[i] <= pv[i-1];
                pw[i] <= pw[i-1];
            end
            case (st)
                IDLE: if (acc) begin
                    sup <= '0;
                    cnt <= '0;
                    bud <= bus.budget;
                    order[0] <= bus.in_index;
                    n <= IDX_W'(1);
                end
                LOAD: if (acc) begin
                    order[n] <= bus.in_index;
                    n <= n + 1'b1;
                    if (n == IDX_W'(DIMEN - 1)) begin
                        rf <= 1'b1;
                        p <= '0;
                    end
                end
                SCAN: if (!stop) begin
                    if (sup[cur])
                        p <= p + 1'b1;
                    else begin
                        tok <= cur;
                        sup[cur] <= 1'b1;
                        wi <= '0;
                    end
                end
                EMIT: if (bus.tok_ready) cnt <= cnt + 1'b1;
                FETCH: begin
                    if (bus.map_ren) wi <= wi + 1'b1;
                    sup <= sup | mask;
                    if (last) p <= p + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_crucial_token_select.sv
// tb_crucial_token_select: table vectors, corner sequences and random frames against a set-based reference model
module tb_crucial_token_select;
    localparam int DIMEN = 32, IDX_W = 5, MAP_W = 16, ADDR_W = 6, MEM_LAT = 2;
    typedef struct {int ordm; int mapm; int bud; int mode; int ecnt; int efirst; int elast;} vec_t;
    logic CLK = 0, RESET = 1, EN = 1;
    always #5 CLK = ~CLK;
    crucial_token_select_if #(.IDX_W(IDX_W), .MAP_W(MAP_W), .ADDR_W(ADDR_W)) bus();
    crucial_token_select #(.DIMEN(DIMEN), .IDX_W(IDX_W), .MAP_W(MAP_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT))
        dut (.CLK(CLK), .RESET(RESET), .EN(EN), .bus(bus));
    logic [MAP_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] ma [MEM_LAT];
    int ord [DIMEN];
    int got [$];
    int exp_q [$];
    int total = 0, bad = 0, ff_n = 0, rf_n = 0, c;
    bit hold = 0, rdy_rand = 0;
    vec_t vt [7];
    always @(posedge CLK) if (EN) begin
        ma[0] <= bus.map_addr;
        for (int i = 1; i < MEM_LAT; i++) ma[i] <= ma[i-1];
    end
    assign bus.map_rdata = mem[ma[MEM_LAT-1]];
    initial begin
        bus.tok_ready = 0;
        forever begin
            @(posedge CLK);
            #2;
            bus.tok_ready = hold ? 1'b0 : rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end
    initial forever begin
        @(negedge CLK);
        if (EN && !RESET && bus.tok_valid && bus.tok_ready) got.push_back(int'(bus.tok_out));
        if (EN && !RESET && bus.find_finish) ff_n++;
        if (EN && !RESET && bus.read_finish) rf_n++;
    end
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic void model(input int bud);
        logic [DIMEN-1:0] s = '0;
        exp_q.delete();
        for (int i = 0; i < DIMEN; i++) begin
            if (bud != 0 && exp_q.size() == bud) break;
            if (!s[ord[i]]) begin
                exp_q.push_back(ord[i]);
                s[ord[i]] = 1'b1;
                for (int j = 0; j < DIMEN; j++)
                    if (mem[ord[i] + (j / MAP_W) * DIMEN][j % MAP_W]) s[j] = 1'b1;
            end
        end
    endfunction
    task automatic setup(input int ordm, input int mapm);
        foreach (mem[a]) mem[a] = '0;
        for (int i = 0; i < DIMEN; i++) ord[i] = ordm == 0 ? DIMEN - 1 - i : i;
        if (mapm == 1) begin
            mem[0] = 16'hFFFE;
            mem[DIMEN] = 16'hFFFF;
        end
        if (mapm == 2) mem[5] = 16'h00C0;
    endtask
    task automatic feed(input int bud);
        for (int i = 0; i < DIMEN; i++) begin
            if (rdy_rand && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 0;
                bus.in_index = IDX_W'($urandom);
                @(posedge CLK);
                #1;
            end
            bus.in_valid = 1;
            bus.in_index = IDX_W'(ord[i]);
            bus.budget = i == 0 ? (IDX_W + 1)'(bud) : (IDX_W + 1)'($urandom);
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 0;
    endtask
    task automatic frame(input int bud, input int mode, input int ecnt, input int efirst, input int elast);
        int k;
        model(bud);
        got.delete();
        ff_n = 0;
        rf_n = 0;
        if (mode == 1) hold = 1;
        feed(bud);
        if (mode == 1) begin
            k = 0;
            do begin @(negedge CLK); k++; end while (!bus.tok_valid && k < 500);
            chk("hold_wait", int'(k < 500), 1);
            repeat (10) begin
                chk("hold_valid", bus.tok_valid, 1);
                chk("hold_tok", bus.tok_out, exp_q[0]);
                chk("hold_no_ren", bus.map_ren, 0);
                @(negedge CLK);
            end
            @(posedge CLK);
            #1 hold = 0;
        end
        if (mode == 2) begin
            k = 0;
            do begin @(negedge CLK); k++; end
            while (!(bus.map_ren && bus.map_addr < DIMEN && got.size() > 0) && k < 500);
            chk("stall_wait", int'(k < 500), 1);
            @(posedge CLK);
            #1 EN = 0;
            repeat (3) begin
                @(negedge CLK);
                chk("stall_ren", bus.map_ren, 1);
                chk("stall_addr", bus.map_addr, got[$] + DIMEN);
                @(posedge CLK);
            end
            #1 EN = 1;
        end
        k = 0;
        while (ff_n == 0 && k < 3000) begin @(negedge CLK); k++; end
        chk("done_wait", int'(ff_n > 0), 1);
        repeat (4) @(negedge CLK);
        chk("find_finish_pulses", ff_n, 1);
        chk("read_finish_pulses", rf_n, 1);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("crucial_cnt", bus.crucial_cnt, exp_q.size());
        chk("tok_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk("tok_list", i < got.size() ? got[i] : -1, exp_q[i]);
        if (ecnt >= 0) begin
            chk("vec_cnt", bus.crucial_cnt, ecnt);
            chk("vec_first", got.size() > 0 ? got[0] : -1, efirst);
            chk("vec_last", got.size() > 0 ? got[$] : -1, elast);
        end
        @(posedge CLK);
        #1;
    endtask
    initial begin
        vt[0] = '{0, 0, 0, 0, 32, 31, 0};
        vt[1] = '{1, 1, 0, 0, 1, 0, 0};
        vt[2] = '{1, 2, 4, 0, 4, 0, 3};
        vt[3] = '{1, 2, 0, 1, 30, 0, 31};
        vt[4] = '{1, 2, 0, 2, 30, 0, 31};
        vt[5] = '{1, 0, 1, 0, 1, 0, 0};
        vt[6] = '{0, 2, 32, 0, 32, 31, 0};
        bus.in_valid = 0;
        bus.in_index = '0;
        bus.budget = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 0;
        @(negedge CLK);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_tok_valid", bus.tok_valid, 0);
        chk("rst_tok_out", bus.tok_out, 0);
        chk("rst_map_ren", bus.map_ren, 0);
        chk("rst_map_addr", bus.map_addr, 0);
        chk("rst_cnt", bus.crucial_cnt, 0);
        chk("rst_find_finish", bus.find_finish, 0);
        chk("rst_read_finish", bus.read_finish, 0);
        @(posedge CLK);
        #1;
        foreach (vt[v]) begin
            rdy_rand = v % 2 == 1;
            setup(vt[v].ordm, vt[v].mapm);
            frame(vt[v].bud, vt[v].mode, vt[v].ecnt, vt[v].efirst, vt[v].elast);
        end
        rdy_rand = 1;
        setup(1, 0);
        model(0);
        got.delete();
        feed(0);
        c = 0;
        do begin @(negedge CLK); c++; end
        while (!(got.size() >= 3 && !bus.tok_valid && !bus.map_ren && !bus.in_ready) && c < 500);
        chk("abort_wait", int'(c < 500), 1);
        ff_n = 0;
        @(posedge CLK);
        #1 RESET = 1;
        @(posedge CLK);
        #1 RESET = 0;
        @(negedge CLK);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_tok_valid", bus.tok_valid, 0);
        chk("abort_cnt", bus.crucial_cnt, 0);
        chk("abort_map_ren", bus.map_ren, 0);
        repeat (40) @(negedge CLK);
        chk("abort_no_finish", ff_n, 0);
        @(posedge CLK);
        #1;
        setup(1, 1);
        frame(0, 0, 1, 0, 0);
        for (int r = 0; r < 8; r++) begin
            foreach (mem[a]) mem[a] = $urandom_range(0, 4) == 0 ? MAP_W'($urandom) & MAP_W'($urandom) : '0;
            for (int i = 0; i < DIMEN; i++) ord[i] = r % 2 == 0 ? i : int'($urandom_range(0, DIMEN - 1));
            if (r % 2 == 0)
                for (int i = DIMEN - 1; i > 0; i--) begin
                    int j, t;
                    j = $urandom_range(0, i);
                    t = ord[i];
                    ord[i] = ord[j];
                    ord[j] = t;
                end
            frame($urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, 10)), r % 3 == 0 ? 2 : 0, -1, -1, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
